// File: rtl/pe_row_conv_pkg.sv
// ============================================================================
// Module   : pe_row_conv_pkg
// Brief    : Shared state encoding, row-config record and pipeline depth for pe_row_conv.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_row_conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } pe_row_state_t;

    typedef struct packed {
        logic       first;
        logic       last;
        logic [4:0] shift;
    } pe_row_cfg_t;

    localparam int PE_ROW_PIPE = 3;

endpackage

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
// Module   : fifo_sync
// Brief    : Single-clock FIFO with show-ahead read data; push into a full FIFO is
//            honoured when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync #(
    parameter int DATA_WIDE = 16,
    parameter int FIFO_DEPT = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [DATA_WIDE-1:0]             wr_data,
    input  logic                             rd_en,
    output logic [DATA_WIDE-1:0]             rd_data,
    output logic                             empty,
    output logic [$clog2(FIFO_DEPT+1)-1:0]   count
);

    localparam int c_AW = $clog2(FIFO_DEPT);
    localparam int c_CW = $clog2(FIFO_DEPT + 1);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(FIFO_DEPT - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPT);

    logic [DATA_WIDE-1:0] r_mem [FIFO_DEPT];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic                 w_do_rd;
    logic                 w_do_wr;

    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && ((r_count != c_FULL) || w_do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_AW'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_do_rd && !w_do_wr) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_requant.sv
// ============================================================================
// Module   : pe_requant
// Brief    : Round-half-up, arithmetic right shift and saturate an accumulator to OUT_W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_requant #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [4:0]       shift,
    output logic [OUT_W-1:0] q
);

    // Headroom so the rounding constant never wraps for any shift up to 31
    localparam int c_EXT_W = ACC_W + 33;
    localparam logic signed [c_EXT_W-1:0] c_QMAX = c_EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [c_EXT_W-1:0] c_QMIN = -c_QMAX - c_EXT_W'(1);

    logic signed [c_EXT_W-1:0] w_ext;
    logic signed [c_EXT_W-1:0] w_rnd;
    logic signed [c_EXT_W-1:0] w_shr;

    always_comb begin
        w_ext = c_EXT_W'(signed'(acc));
        w_rnd = '0;
        if (shift != 5'd0) begin
            w_rnd = c_EXT_W'(1) << (shift - 5'd1);
        end
        w_shr = (w_ext + w_rnd) >>> shift;
        if (w_shr > c_QMAX) begin
            q = OUT_W'(c_QMAX);
        end else if (w_shr < c_QMIN) begin
            q = OUT_W'(c_QMIN);
        end else begin
            q = OUT_W'(w_shr);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_row_conv.sv
// ============================================================================
// Module   : pe_row_conv
// Brief    : Streaming 1-D convolution PE with runtime kernel width, multi-row psum
//            accumulation, requantisation and a back-pressured output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_row_conv
    import pe_row_conv_pkg::*;
#(
    parameter int ACT_W      = 8,
    parameter int KMAX       = 5,
    parameter int ROW_MAX    = 32,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [$clog2(KMAX+1)-1:0]    cfg_k,
    input  logic [$clog2(ROW_MAX+1)-1:0] cfg_row_len,
    input  logic                         cfg_first,
    input  logic                         cfg_last,
    input  logic                         cfg_keep_w,
    input  logic [4:0]                   cfg_shift,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [ACT_W-1:0]             w_data,
    input  logic                         act_valid,
    output logic                         act_ready,
    input  logic [ACT_W-1:0]             act_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    output logic                         busy,
    output logic                         err_cfg
);

    localparam int c_KW = $clog2(KMAX + 1);
    localparam int c_RW = $clog2(ROW_MAX + 1);
    localparam int c_JW = $clog2(ROW_MAX);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_PW = 2 * ACT_W;
    localparam logic [c_KW-1:0] c_KMAX    = c_KW'(KMAX);
    localparam logic [c_RW-1:0] c_ROW_MAX = c_RW'(ROW_MAX);
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(FIFO_DEPTH);

    pe_row_state_t             r_state, w_state_nxt;
    pe_row_cfg_t               r_cfg;
    logic [c_KW-1:0]           r_k, r_w_idx;
    logic [c_RW-1:0]           r_row_len, r_act_cnt;
    logic                      r_err_cfg, r_v1, r_v2;
    logic [c_JW-1:0]           r_j1;
    logic signed [ACT_W-1:0]   r_w   [KMAX];
    logic signed [ACT_W-1:0]   r_win [KMAX-1];
    logic signed [c_PW-1:0]    r_prod [KMAX];
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   r_rowbuf [ROW_MAX];

    logic                      w_cfg_legal, w_cfg_acc, w_cfg_rej;
    logic                      w_w_fire, w_act_fire, w_win_full;
    logic [$clog2(PE_ROW_PIPE)-1:0] w_inflight;
    logic [c_CW-1:0]           w_fifo_count;
    logic                      w_fifo_empty;
    logic signed [ACT_W-1:0]   w_age [KMAX];
    logic signed [ACT_W-1:0]   w_sel [KMAX];
    logic signed [c_PW-1:0]    w_prod [KMAX];
    logic signed [ACC_W-1:0]   w_sum, w_base, w_acc;
    logic [OUT_W-1:0]          w_q;

    assign w_cfg_legal = (cfg_k != '0) && (cfg_k <= c_KMAX) &&
                         (cfg_row_len >= c_RW'(cfg_k)) && (cfg_row_len <= c_ROW_MAX);
    assign w_cfg_acc   = (r_state == IDLE) && cfg_valid && w_cfg_legal;
    assign w_cfg_rej   = (r_state == IDLE) && cfg_valid && !w_cfg_legal;
    assign w_w_fire    = w_valid && w_ready;
    assign w_act_fire  = act_valid && act_ready;
    assign w_win_full  = (r_act_cnt >= c_RW'(r_k) - c_RW'(1));

    assign cfg_ready = (r_state == IDLE);
    assign w_ready   = (r_state == LOAD_W);
    // Counting results still in the pipe keeps the FIFO from ever overflowing
    assign act_ready = (r_state == RUN) && ((w_fifo_count + c_CW'(w_inflight)) < c_DEPTH);
    assign busy      = (r_state != IDLE) || r_v1 || r_v2 || !w_fifo_empty;
    assign err_cfg   = r_err_cfg;
    assign out_valid = !w_fifo_empty;

    always_comb begin
        w_inflight = '0;
        if (r_cfg.last) begin
            w_inflight = {1'b0, r_v1} + {1'b0, r_v2};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cfg_acc) w_state_nxt = cfg_keep_w ? RUN : LOAD_W;
            LOAD_W:  if (w_w_fire && (r_w_idx == r_k - c_KW'(1))) w_state_nxt = RUN;
            RUN:     if (w_act_fire && (r_act_cnt == r_row_len - c_RW'(1))) w_state_nxt = DRAIN;
            DRAIN:   if (!r_v1 && !r_v2) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Window indexed by age (0 = activation being accepted now); tap t pairs with age k-1-t
    always_comb begin
        w_age[0] = act_data;
        for (int i = 1; i < KMAX; i++) begin
            w_age[i] = r_win[i-1];
        end
        for (int t = 0; t < KMAX; t++) begin
            w_sel[t] = '0;
            for (int i = 0; i < KMAX; i++) begin
                if (int'(r_k) - 1 - t == i) w_sel[t] = w_age[i];
            end
            w_prod[t] = '0;
            if (t < int'(r_k)) begin
                w_prod[t] = r_w[t] * w_sel[t];
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int t = 0; t < KMAX; t++) begin
            w_sum = w_sum + ACC_W'(r_prod[t]);
        end
        w_base = r_cfg.first ? '0 : r_rowbuf[r_j1];
        w_acc  = w_sum + w_base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cfg     <= '0;
            r_k       <= '0;
            r_row_len <= '0;
            r_w_idx   <= '0;
            r_act_cnt <= '0;
            r_err_cfg <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_j1      <= '0;
            r_acc     <= '0;
            for (int t = 0; t < KMAX; t++) begin
                r_w[t]    <= '0;
                r_prod[t] <= '0;
            end
            for (int i = 0; i < KMAX - 1; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_err_cfg <= w_cfg_rej;
            if (w_cfg_acc) begin
                r_k       <= cfg_k;
                r_row_len <= cfg_row_len;
                r_cfg     <= '{first: cfg_first, last: cfg_last, shift: cfg_shift};
                r_w_idx   <= '0;
                r_act_cnt <= '0;
            end
            if (w_w_fire) begin
                r_w[r_w_idx] <= w_data;
                r_w_idx      <= r_w_idx + c_KW'(1);
            end
            r_v1 <= w_act_fire && w_win_full;
            if (w_act_fire) begin
                r_act_cnt <= r_act_cnt + c_RW'(1);
                r_win[0]  <= act_data;
                for (int i = 1; i < KMAX - 1; i++) begin
                    r_win[i] <= r_win[i-1];
                end
                if (w_win_full) begin
                    r_prod <= w_prod;
                    r_j1   <= c_JW'(r_act_cnt - (c_RW'(r_k) - c_RW'(1)));
                end
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_acc <= w_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_v1 && !r_cfg.last) begin
            r_rowbuf[r_j1] <= w_acc;
        end
    end

    pe_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .acc   (r_acc),
        .shift (r_cfg.shift),
        .q     (w_q)
    );

    fifo_sync #(
        .DATA_WIDE (OUT_W),
        .FIFO_DEPT (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_v2 && r_cfg.last),
        .wr_data (w_q),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

endmodule

`default_nettype wire
